// File: rtl/accum_frame_ctrl.sv
// Frame accumulator in front of an external 4-bit combinational adder.
// Sums a valid/ready stream of nibbles into an 8-bit total per frame.
module accum_frame_ctrl #(
    parameter int unsigned MAX_OPS = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic       in_last,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    input  logic [3:0] add_s,
    input  logic       add_c,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_sum,
    output logic [3:0] out_count,
    output logic       out_err
);

    localparam logic [0:0] StAcc = 1'b0;
    localparam logic [0:0] StOut = 1'b1;

    localparam logic [3:0] MaxCnt = 4'(MAX_OPS);

    logic [0:0] state_q, state_d;
    logic [3:0] acc_lo_q, acc_lo_d;
    logic [3:0] acc_hi_q, acc_hi_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] out_sum_q, out_sum_d;
    logic [3:0] out_count_q, out_count_d;
    logic       out_err_q, out_err_d;

    logic       accept;
    logic       close;
    logic [3:0] cnt_inc;
    logic [3:0] acc_hi_inc;

    assign in_ready  = (state_q == StAcc);
    assign out_valid = (state_q == StOut);
    assign add_a     = acc_lo_q;
    assign add_b     = in_data;

    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_err   = out_err_q;

    assign accept     = in_valid & in_ready;
    assign cnt_inc    = cnt_q + 4'd1;
    assign acc_hi_inc = acc_hi_q + {3'b000, add_c};
    // Force-close at MAX_OPS keeps the 8-bit total from ever wrapping.
    assign close      = accept & (in_last | (cnt_inc == MaxCnt));

    always_comb begin
        state_d     = state_q;
        acc_lo_d    = acc_lo_q;
        acc_hi_d    = acc_hi_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_err_d   = out_err_q;

        unique case (state_q)
            StAcc: begin
                if (accept) begin
                    acc_lo_d = add_s;
                    acc_hi_d = acc_hi_inc;
                    cnt_d    = cnt_inc;
                end
                if (close) begin
                    state_d     = StOut;
                    out_sum_d   = {acc_hi_inc, add_s};
                    out_count_d = cnt_inc;
                    out_err_d   = ~in_last;
                end
            end
            StOut: begin
                // Result registers keep their value after the handshake.
                if (out_ready) begin
                    state_d  = StAcc;
                    acc_lo_d = 4'd0;
                    acc_hi_d = 4'd0;
                    cnt_d    = 4'd0;
                end
            end
            default: begin
                state_d = StAcc;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StAcc;
            acc_lo_q    <= 4'd0;
            acc_hi_q    <= 4'd0;
            cnt_q       <= 4'd0;
            out_sum_q   <= 8'd0;
            out_count_q <= 4'd0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_lo_q    <= acc_lo_d;
            acc_hi_q    <= acc_hi_d;
            cnt_q       <= cnt_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_err_q   <= out_err_d;
        end
    end

endmodule

// File: tb/tb_accum_frame_ctrl.sv
// Randomized bench for accum_frame_ctrl against a frame-level reference model.
// The 4-bit adder the block drives is modelled here as plain addition.
module tb_accum_frame_ctrl;

    localparam int unsigned MAX_OPS = 15;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_last;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic [3:0] add_s;
    logic       add_c;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic [3:0] out_count;
    logic       out_err;

    int unsigned n_checks;
    int unsigned n_fail;

    // Reference model: running total of the open frame plus the pending result.
    int unsigned m_total;
    int unsigned m_cnt;
    bit          m_pending;
    int unsigned e_sum;
    int unsigned e_cnt;
    bit          e_err;
    int unsigned n_frames;
    int unsigned n_forced;

    accum_frame_ctrl #(
        .MAX_OPS(MAX_OPS)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_s    (add_s),
        .add_c    (add_c),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_count(out_count),
        .out_err  (out_err)
    );

    assign {add_c, add_s} = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_total   = 0;
        m_cnt     = 0;
        m_pending = 0;
        e_sum     = 0;
        e_cnt     = 0;
        e_err     = 0;
    endtask

    task automatic check_outputs();
        check_val("in_ready", 32'(in_ready), m_pending ? 0 : 1);
        check_val("out_valid", 32'(out_valid), m_pending ? 1 : 0);
        check_val("add_a", 32'(add_a), m_total % 16);
        check_val("add_b", 32'(add_b), 32'(in_data));
        if (m_pending) begin
            check_val("out_sum", 32'(out_sum), e_sum);
            check_val("out_count", 32'(out_count), e_cnt);
            check_val("out_err", 32'(out_err), 32'(e_err));
        end
    endtask

    // Advance the model across the coming rising edge using the current inputs.
    task automatic model_step();
        if (!m_pending) begin
            if (in_valid) begin
                m_total += 32'(in_data);
                m_cnt++;
                if (in_last || m_cnt == MAX_OPS) begin
                    m_pending = 1;
                    e_sum     = m_total;
                    e_cnt     = m_cnt;
                    e_err     = !in_last;
                    n_frames++;
                    if (!in_last) n_forced++;
                end
            end
        end else if (out_ready) begin
            m_pending = 0;
            m_total   = 0;
            m_cnt     = 0;
        end
    endtask

    task automatic cycle(input logic v, input logic [3:0] d, input logic l, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        @(negedge clk);
        check_outputs();
        model_step();
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 1'b0, r);
    endtask

    // Asynchronous reset between edges; state must clear without a clock.
    task automatic async_reset();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_out_valid", 32'(out_valid), 0);
        check_val("rst_in_ready", 32'(in_ready), 1);
        check_val("rst_add_a", 32'(add_a), 0);
        check_val("rst_out_sum", 32'(out_sum), 0);
        check_val("rst_out_count", 32'(out_count), 0);
        check_val("rst_out_err", 32'(out_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_frames  = 0;
        n_forced  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_out_sum", 32'(out_sum), 0);
        check_val("reset_out_count", 32'(out_count), 0);
        check_val("reset_out_err", 32'(out_err), 0);
        rst_n = 1'b1;
        idle(1, 1'b1);

        // {5,6}
        cycle(1'b1, 4'd5, 1'b0, 1'b1);
        cycle(1'b1, 4'd6, 1'b1, 1'b1);
        idle(2, 1'b1);

        // {15,15,15}
        cycle(1'b1, 4'd15, 1'b0, 1'b1);
        cycle(1'b1, 4'd15, 1'b0, 1'b1);
        cycle(1'b1, 4'd15, 1'b1, 1'b1);
        idle(2, 1'b1);

        // {9}, result stalled 3 cycles with a new beat waiting upstream
        cycle(1'b1, 4'd9, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'd2, 1'b0, 1'b0);
        cycle(1'b1, 4'd2, 1'b0, 1'b1);
        cycle(1'b1, 4'd2, 1'b1, 1'b1);
        idle(3, 1'b1);

        // 15 x 15 without in_last: forced close, then a fresh frame
        for (int i = 0; i < 15; i++) cycle(1'b1, 4'd15, 1'b0, 1'b1);
        idle(1, 1'b1);
        cycle(1'b1, 4'd1, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Reset mid-frame after {7,8}, then {3}
        cycle(1'b1, 4'd7, 1'b0, 1'b1);
        cycle(1'b1, 4'd8, 1'b0, 1'b1);
        async_reset();
        cycle(1'b1, 4'd3, 1'b1, 1'b1);
        idle(2, 1'b1);

        // {1,2} and {4} with gaps; in_last without in_valid must be ignored
        cycle(1'b1, 4'd1, 1'b0, 1'b1);
        cycle(1'b0, 4'd9, 1'b1, 1'b1);
        cycle(1'b1, 4'd2, 1'b1, 1'b1);
        idle(2, 1'b1);
        cycle(1'b1, 4'd4, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Reset while a result is pending
        cycle(1'b1, 4'd6, 1'b1, 1'b0);
        idle(1, 1'b0);
        async_reset();
        idle(1, 1'b1);

        // Random traffic, short frames
        for (int i = 0; i < 600; i++) begin
            cycle(1'(($urandom % 10) < 7), 4'($urandom), 1'(($urandom % 4) == 0),
                  1'(($urandom % 10) < 6));
        end

        // Random traffic, long frames that often hit the force-close
        for (int i = 0; i < 600; i++) begin
            cycle(1'(($urandom % 10) < 8), 4'($urandom), 1'(($urandom % 40) == 0),
                  1'(($urandom % 10) < 7));
        end
        idle(3, 1'b1);

        check_val("frames_seen_nonzero", 32'(n_frames > 20), 1);
        check_val("forced_closes_seen", 32'(n_forced > 2), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
